addsub_multicycle: RTL and testbench

Parametrised multi-cycle add/subtract unit for the ALU datapath, the sequential successor to the fixed 32-bit combinational subtractor. It processes the operands one SLICE-bit chunk per clock through a single narrow adder with a registered carry chain, trading latency for area. It adds an add/sub mode select, a start/busy/done handshake and a full status-flag set (carry, overflow, zero, negative). It sits between the operand registers and the ALU result mux.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/slice_addsub.sv | 33 +++
 rtl/addsub_multicycle.sv | 172 +++++++++++++++++
 tb/tb_addsub_multicycle.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Contents:
//   MODE_ADD / MODE_SUB : add/sub mode select encodings
//   state_t             : sequencer states of the multi-cycle add/sub unit
//   flags_t             : status flag bundle (carry, overflow, zero, negative),
//                         intended for reuse by other ALU operations
package alu_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/slice_addsub.sv
// One SLICE-bit add/subtract step with a carry in and a carry out.
// Ports:
//   a_i, b_i : SLICE-bit operand chunks
//   cin      : carry into the low bit of the slice
//   sub      : 1 = invert b_i (subtract step; the +1 arrives through cin)
//   sum      : SLICE-bit result chunk
//   cout     : carry out of the top bit of the slice
//   c_msb    : carry into the top bit of the slice (for signed overflow)
module slice_addsub #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin,
  input  logic             sub,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] w_b_eff;
  logic [SLICE:0]   w_full;

  assign w_b_eff = b_i ^ {SLICE{sub}};
  assign w_full  = {1'b0, a_i} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, cin};
  assign sum     = w_full[SLICE-1:0];
  assign cout    = w_full[SLICE];
  // The sum bit at the top position is a ^ b ^ carry_in, so the carry into
  // that bit falls out by XORing the operand bits back off. This form also
  // works for SLICE = 1.
  assign c_msb   = w_full[SLICE-1] ^ a_i[SLICE-1] ^ w_b_eff[SLICE-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle add/subtract unit: one SLICE-bit chunk per clock through a
// single narrow adder with a registered carry between chunks.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only while idle; a, b, mode captured with it
//   mode        : 0 = a + b, 1 = a - b
//   a, b        : WIDTH-bit operands
//   busy        : high while an operation is in progress
//   done        : one-cycle pulse; y and flags update on the same edge
//   y           : result, held until the next done
//   carry       : carry out of MSB (subtract: 1 = no borrow)
//   overflow    : two's-complement signed overflow
//   zero        : y == 0
//   negative    : y[WIDTH-1]
//   dbg_state   : current sequencer state, for observation only
//
// Handshake: start is accepted on a rising edge where start = 1 and
// busy = 0; starts seen while busy = 1 are dropped without effect. done is
// asserted for exactly one cycle per accepted operation (unless reset
// aborts it), and y/flags change only on the edge that raises done.
//
// WIDTH must be a multiple of SLICE.
module addsub_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output state_t           dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_y;
  logic             r_mode;
  logic             r_carry;
  logic             r_done;
  logic [IDXW-1:0]  r_idx;
  flags_t           r_flags;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic             w_last;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_res_final;
  flags_t           w_flags_final;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_a_slice = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_b_slice = r_b[int'(r_idx)*SLICE +: SLICE];

  slice_addsub #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i   (w_a_slice),
    .b_i   (w_b_slice),
    .cin   (r_carry),
    .sub   (r_mode),
    .sum   (w_sum),
    .cout  (w_cout),
    .c_msb (w_c_msb)
  );

  // Sequencer: next state and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // On the completing cycle the top slice is still only on the adder
  // output, so the visible result and its flags are assembled from the
  // partial result register with the final slice spliced into the top.
  always_comb begin
    w_res_final                    = r_res;
    w_res_final[WIDTH-1 -: SLICE]  = w_sum;
    w_flags_final.carry            = w_cout;
    w_flags_final.overflow         = w_c_msb ^ w_cout;
    w_flags_final.zero             = (w_res_final == '0);
    w_flags_final.negative         = w_res_final[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_y     <= '0;
      r_mode  <= MODE_ADD;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
      r_flags <= FLAGS_CLEAR;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_finish;

      if (w_load) begin
        r_a     <= a;
        r_b     <= b;
        r_mode  <= mode;
        // Subtract is a + ~b + 1: the +1 enters as the initial carry.
        r_carry <= mode;
        r_idx   <= '0;
      end

      if (w_step) begin
        r_res[int'(r_idx)*SLICE +: SLICE] <= w_sum;
        r_carry                           <= w_cout;
        r_idx                             <= w_last ? '0 : r_idx + 1'b1;
      end

      if (w_finish) begin
        r_y     <= w_res_final;
        r_flags <= w_flags_final;
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = r_done;
  assign y         = r_y;
  assign carry     = r_flags.carry;
  assign overflow  = r_flags.overflow;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed bench for addsub_multicycle with three instances:
//   inst 0: WIDTH=32 SLICE=8  (latency 5)
//   inst 1: WIDTH=32 SLICE=32 (latency 2)
//   inst 2: WIDTH=32 SLICE=4  (latency 9)
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_addsub_multicycle;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic        mode_v  [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] y_v     [3];
  logic        c_v     [3];
  logic        o_v     [3];
  logic        z_v     [3];
  logic        n_v     [3];
  state_t      st_v    [3];

  int tests = 0;
  int fails = 0;
  int lat_exp [3] = '{5, 2, 9};

  addsub_multicycle #(.WIDTH(32), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]),
    .carry(c_v[0]), .overflow(o_v[0]), .zero(z_v[0]), .negative(n_v[0]),
    .dbg_state(st_v[0])
  );

  addsub_multicycle #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]),
    .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]),
    .carry(c_v[1]), .overflow(o_v[1]), .zero(z_v[1]), .negative(n_v[1]),
    .dbg_state(st_v[1])
  );

  addsub_multicycle #(.WIDTH(32), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]),
    .a(a_v[2]), .b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]),
    .carry(c_v[2]), .overflow(o_v[2]), .zero(z_v[2]), .negative(n_v[2]),
    .dbg_state(st_v[2])
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic and sign-rule overflow.
  task automatic model(input logic m, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] ey, output logic [3:0] ef);
    logic [32:0] s;
    logic        ov;
    if (m) s = {1'b0, aa} + {1'b0, ~bb} + 33'd1;
    else   s = {1'b0, aa} + {1'b0, bb};
    ey = s[31:0];
    if (m) ov = (aa[31] != bb[31]) && (ey[31] != aa[31]);
    else   ov = (aa[31] == bb[31]) && (ey[31] != aa[31]);
    ef = {s[32], ov, (ey == 32'd0), ey[31]};
  endtask

  // Driver: present a request at the current falling edge.
  task automatic issue(input int inst, input logic m, input logic [31:0] aa, input logic [31:0] bb);
    mode_v[inst]  = m;
    a_v[inst]     = aa;
    b_v[inst]     = bb;
    start_v[inst] = 1'b1;
  endtask

  // Counts rising edges from the one that samples start until done is seen.
  // A nonzero inject_at pulses a competing start on that cycle.
  task automatic wait_done(input int inst, input int inject_at, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) start_v[inst] = 1'b0;
      if (inject_at != 0 && c == inject_at) issue(inst, MODE_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      if (inject_at != 0 && c == inject_at + 1) start_v[inst] = 1'b0;
      if (busy_v[inst]) bcnt++;
      if (done_v[inst]) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input int inst, input logic [31:0] ey, input logic [3:0] ef);
    chk({tag, ".y"}, 64'(y_v[inst]), 64'(ey));
    chk({tag, ".flags"}, 64'({c_v[inst], o_v[inst], z_v[inst], n_v[inst]}), 64'(ef));
  endtask

  task automatic run_op(input string tag, input int inst, input logic m, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] ey, input logic [3:0] ef);
    int lat;
    int bc;
    issue(inst, m, aa, bb);
    wait_done(inst, 0, lat, bc);
    chk({tag, ".lat"}, 64'(lat), 64'(lat_exp[inst]));
    check_out(tag, inst, ey, ef);
  endtask

  initial begin
    int          lat;
    int          bc;
    int          done_seen;
    int          busy_seen;
    logic        m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ey;
    logic [3:0]  ef;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state of every instance.
    for (int i = 0; i < 3; i++) begin
      chk("rst.busy", 64'(busy_v[i]), 64'd0);
      chk("rst.done", 64'(done_v[i]), 64'd0);
      chk("rst.state", 64'(st_v[i]), 64'(IDLE));
      check_out("rst", i, 32'h0, 4'b0000);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Sub with latency and busy-length check: flags are {c,v,z,n}.
    issue(0, MODE_SUB, 32'hFFFF_FFFB, 32'h0000_0003);
    wait_done(0, 0, lat, bc);
    chk("sub1.lat", 64'(lat), 64'd5);
    chk("sub1.busy_cycles", 64'(bc), 64'd4);
    check_out("sub1", 0, 32'hFFFF_FFF8, 4'b1001);
    @(negedge clk);
    chk("sub1.done_pulse", 64'(done_v[0]), 64'd0);

    run_op("sub_ovf", 0, MODE_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100);
    run_op("sub_zero", 0, MODE_SUB, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 4'b1010);
    run_op("add_wrap", 0, MODE_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
    run_op("add_ovf", 0, MODE_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101);
    run_op("add_small", 0, MODE_ADD, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000);

    // A start pulsed while busy must be dropped.
    issue(0, MODE_ADD, 32'h1234_5678, 32'h1111_1111);
    wait_done(0, 2, lat, bc);
    chk("ign.lat", 64'(lat), 64'd5);
    check_out("ign", 0, 32'h2345_6789, 4'b0000);
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_v[0]) done_seen++;
      if (busy_v[0]) busy_seen++;
    end
    chk("ign.extra_done", 64'(done_seen), 64'd0);
    chk("ign.extra_busy", 64'(busy_seen), 64'd0);

    // Back-to-back: second start presented during the done cycle.
    run_op("b2b_first", 0, MODE_SUB, 32'h0000_000A, 32'h0000_0014, 32'hFFFF_FFF6, 4'b0001);
    run_op("b2b_second", 0, MODE_ADD, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 4'b0000);

    // Reset in the middle of RUN aborts with no done.
    @(negedge clk);
    issue(0, MODE_ADD, 32'h0000_0001, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort.busy_before", 64'(busy_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy_v[0]), 64'd0);
    chk("abort.done", 64'(done_v[0]), 64'd0);
    chk("abort.state", 64'(st_v[0]), 64'(IDLE));
    check_out("abort", 0, 32'h0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_v[0]) done_seen++;
    end
    chk("abort.no_done", 64'(done_seen), 64'd0);
    run_op("after_abort", 0, MODE_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000);

    // Other slice widths: same vector, different latency.
    run_op("s32.sub1", 1, MODE_SUB, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFF8, 4'b1001);
    run_op("s4.sub1", 2, MODE_SUB, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFF8, 4'b1001);
    run_op("s4.sub_ovf", 2, MODE_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100);
    run_op("s32.add_ovf", 1, MODE_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101);

    // Random operations spread over all three widths.
    for (int i = 0; i < 1000; i++) begin
      m  = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      model(m, ra, rb, ey, ef);
      run_op($sformatf("rnd%0d", i), i % 3, m, ra, rb, ey, ef);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
